// File: rtl/reg_dump.sv
// reg_dump: walks a register file from START_ADDR to END_ADDR two registers at
// a time (read ports A and B) and streams each register out as one word on a
// valid/ready interface, tagged with its address.
//
// Optional feature: define REG_DUMP_CHECKSUM_EN to append a checksum word
// (32-bit wrap-around sum of all data words, out_addr=0) as the final word.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               dump request, sampled only while idle
//   busy, done          activity flag, one-cycle completion pulse
//   rd_addr_A/B         register-file read addresses (cur, cur+1)
//   rd_data_A/B         combinational register-file read data
//   out_valid/ready     stream handshake
//   out_data/addr/last  stream word, its register address, final-word marker
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// FETCH  | latch read data of cur and cur+1
// SEND_A | offer register cur
// SEND_B | offer register cur+1
// CKSUM  | offer checksum word (REG_DUMP_CHECKSUM_EN only)
// DONE   | one-cycle done pulse

module reg_dump #(
  parameter int START_ADDR = 1,
  parameter int END_ADDR   = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr_A,
  output logic [4:0]  rd_addr_B,
  input  logic [31:0] rd_data_A,
  input  logic [31:0] rd_data_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_addr,
  output logic        out_last
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
`ifdef REG_DUMP_CHECKSUM_EN
    CKSUM  = 3'd4,
`endif
    DONE   = 3'd5
  } state_t;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam state_t END_ST = CKSUM;
`else
  localparam state_t END_ST = DONE;
`endif

  localparam logic [4:0] START_A = 5'(START_ADDR);
  localparam logic [4:0] END_A   = 5'(END_ADDR);
  localparam logic [5:0] END_6   = 6'(END_ADDR);

  state_t      state_q, state_d;
  logic [4:0]  cur_q, cur_d;
  logic [31:0] buf_a_q, buf_a_d;
  logic [31:0] buf_b_q, buf_b_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
`endif

  logic [4:0] cur_p1;
  logic [5:0] cur_p2;

  // cur+2 is computed one bit wider so that stepping past address 31
  // cannot wrap around and look like another in-range pair.
  assign cur_p1 = cur_q + 5'd1;
  assign cur_p2 = {1'b0, cur_q} + 6'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= 5'd0;
      buf_a_q <= 32'd0;
      buf_b_q <= 32'd0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    buf_a_d   = buf_a_q;
    buf_b_d   = buf_b_q;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_d     = acc_q;
`endif
    busy      = 1'b0;
    done      = 1'b0;
    rd_addr_A = 5'd0;
    rd_addr_B = 5'd0;
    out_valid = 1'b0;
    out_data  = 32'd0;
    out_addr  = 5'd0;
    out_last  = 1'b0;

    if (state_q != IDLE) begin
      busy      = 1'b1;
      rd_addr_A = cur_q;
      rd_addr_B = cur_p1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = START_A;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d   = 32'd0;
`endif
          state_d = FETCH;
        end
      end

      FETCH: begin
        buf_a_d = rd_data_A;
        buf_b_d = rd_data_B;
        state_d = SEND_A;
      end

      SEND_A: begin
        out_valid = 1'b1;
        out_data  = buf_a_q;
        out_addr  = cur_q;
`ifndef REG_DUMP_CHECKSUM_EN
        out_last  = (cur_q == END_A);
`endif
        if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d = acc_q + buf_a_q;
`endif
          state_d = (cur_q < END_A) ? SEND_B : END_ST;
        end
      end

      SEND_B: begin
        out_valid = 1'b1;
        out_data  = buf_b_q;
        out_addr  = cur_p1;
`ifndef REG_DUMP_CHECKSUM_EN
        out_last  = (cur_p1 == END_A);
`endif
        if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d = acc_q + buf_b_q;
`endif
          cur_d   = cur_p2[4:0];
          state_d = (cur_p2 <= END_6) ? FETCH : END_ST;
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      CKSUM: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        out_addr  = 5'd0;
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
